// File: rtl/parking_exit_gate_if.sv
// Signal bundle between the exit-gate controller and its sensors/ticket reader.
// The slave modport is the gate controller; the master modport is the field side.
interface parking_exit_gate_if;
    logic       sensor_exit;
    logic       sensor_gone;
    logic [3:0] ticket;
    logic       ticket_valid;
    logic [3:0] countcar;
    logic       GREEN_LED;
    logic       RED_LED;
    logic [2:0] indicator;
    logic       car_left;
    logic [1:0] attempts;
    logic       alarm;

    modport master (
        output sensor_exit, sensor_gone, ticket, ticket_valid, countcar,
        input  GREEN_LED, RED_LED, indicator, car_left, attempts, alarm
    );

    modport slave (
        input  sensor_exit, sensor_gone, ticket, ticket_valid, countcar,
        output GREEN_LED, RED_LED, indicator, car_left, attempts, alarm
    );
endinterface

// File: rtl/parking_exit_gate.sv
// Parking exit barrier controller: Moore FSM checking exit tickets, with timeout,
// wrong-ticket lockout and empty-lot fault detection.
module parking_exit_gate #(
    parameter logic [3:0] EXIT_CODE    = 4'b1011,
    parameter logic [7:0] WAIT_LIMIT   = 8'd30,
    parameter logic [1:0] MAX_ATTEMPTS = 2'd3
) (
    input logic                  clk,
    input logic                  reset,
    parking_exit_gate_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE        = 3'b000,
        WAIT_TICKET = 3'b001,
        WRONG       = 3'b010,
        OPEN        = 3'b011,
        FAULT       = 3'b100,
        LOCKOUT     = 3'b101
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] timer_q, timer_d;
    logic [1:0] attempts_q, attempts_d;
    logic       car_left_q, car_left_d;
    logic       green_q, green_d;
    logic       red_q, red_d;
    logic       alarm_q, alarm_d;
    logic [1:0] attempts_inc;
    logic       ticket_ok;

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        attempts_d   = attempts_q;
        car_left_d   = 1'b0;
        // Saturating increment so the counter can never wrap past the lockout limit
        attempts_inc = (attempts_q == MAX_ATTEMPTS) ? attempts_q : attempts_q + 2'd1;
        ticket_ok    = (bus.ticket == EXIT_CODE);

        case (state_q)
            IDLE: begin
                timer_d    = '0;
                attempts_d = '0;
                if (bus.sensor_exit) begin
                    state_d = (bus.countcar != '0) ? WAIT_TICKET : FAULT;
                end
            end
            WAIT_TICKET: begin
                if (bus.ticket_valid) begin
                    if (ticket_ok) begin
                        state_d = OPEN;
                    end else begin
                        attempts_d = attempts_inc;
                        state_d    = (attempts_inc == MAX_ATTEMPTS) ? LOCKOUT : WRONG;
                    end
                end else if (timer_q == WAIT_LIMIT - 8'd1) begin
                    state_d    = IDLE;
                    timer_d    = '0;
                    attempts_d = '0;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            WRONG: begin
                if (bus.ticket_valid) begin
                    if (ticket_ok) begin
                        state_d = OPEN;
                    end else begin
                        attempts_d = attempts_inc;
                        state_d    = (attempts_inc == MAX_ATTEMPTS) ? LOCKOUT : WRONG;
                    end
                end
            end
            OPEN: begin
                // A second car already waiting (tailgate) goes straight back to ticket check
                if (bus.sensor_gone) begin
                    car_left_d = 1'b1;
                    attempts_d = '0;
                    timer_d    = '0;
                    state_d    = bus.sensor_exit ? WAIT_TICKET : IDLE;
                end
            end
            FAULT: begin
                if (!bus.sensor_exit) begin
                    state_d = IDLE;
                end
            end
            LOCKOUT: begin
                state_d = LOCKOUT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        green_d = (state_d == OPEN);
        red_d   = (state_d inside {WAIT_TICKET, WRONG, FAULT, LOCKOUT});
        alarm_d = (state_d inside {FAULT, LOCKOUT});
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            attempts_q <= '0;
            car_left_q <= 1'b0;
            green_q    <= 1'b0;
            red_q      <= 1'b0;
            alarm_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            attempts_q <= attempts_d;
            car_left_q <= car_left_d;
            green_q    <= green_d;
            red_q      <= red_d;
            alarm_q    <= alarm_d;
        end
    end

    assign bus.indicator = state_q;
    assign bus.GREEN_LED = green_q;
    assign bus.RED_LED   = red_q;
    assign bus.alarm     = alarm_q;
    assign bus.car_left  = car_left_q;
    assign bus.attempts  = attempts_q;

endmodule

// File: tb/tb_parking_exit_gate.sv
// Scoreboard bench for parking_exit_gate: stimulus queues cycle-tagged expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_parking_exit_gate;

  logic clk;
  logic reset;
  int   cyc;
  int   total_checks;
  int   passed_checks;

  parking_exit_gate_if bus_if ();

  parking_exit_gate #(
    .EXIT_CODE   (4'b1011),
    .WAIT_LIMIT  (8'd30),
    .MAX_ATTEMPTS(2'd3)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_if.slave)
  );

  typedef struct {
    int         cyc;
    string      name;
    logic [8:0] vec;   // {indicator, green, red, alarm, car_left, attempts}
  } exp_t;

  exp_t sb[$];

  localparam logic [2:0] S_IDLE  = 3'b000;
  localparam logic [2:0] S_WAIT  = 3'b001;
  localparam logic [2:0] S_WRONG = 3'b010;
  localparam logic [2:0] S_OPEN  = 3'b011;
  localparam logic [2:0] S_FAULT = 3'b100;
  localparam logic [2:0] S_LOCK  = 3'b101;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // {green, red, alarm} for each state code
  function automatic logic [2:0] leds(input logic [2:0] ind);
    case (ind)
      S_IDLE:          leds = 3'b000;
      S_WAIT, S_WRONG: leds = 3'b010;
      S_OPEN:          leds = 3'b100;
      S_FAULT, S_LOCK: leds = 3'b011;
      default:         leds = 3'b000;
    endcase
  endfunction

  // Expected outputs after the next rising edge
  task automatic exp_out(input string name, input logic [2:0] ind,
                         input logic [1:0] att, input logic cl);
    exp_t e;
    e.cyc  = cyc + 1;
    e.name = name;
    e.vec  = {ind, leds(ind), cl, att};
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    logic [8:0] act;
    act = {bus_if.indicator, bus_if.GREEN_LED, bus_if.RED_LED, bus_if.alarm,
           bus_if.car_left, bus_if.attempts};
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      total_checks++;
      if (sb[0].cyc == cyc && act === sb[0].vec) begin
        passed_checks++;
      end else begin
        $display("FAIL %s cyc=%0d: got ind=%b g=%b r=%b al=%b cl=%b att=%b, want ind=%b g=%b r=%b al=%b cl=%b att=%b",
                 sb[0].name, cyc, act[8:6], act[5], act[4], act[3], act[2], act[1:0],
                 sb[0].vec[8:6], sb[0].vec[5], sb[0].vec[4], sb[0].vec[3],
                 sb[0].vec[2], sb[0].vec[1:0]);
      end
      void'(sb.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d expectations pending", sb.size());
    $fatal(1);
  end

  initial begin
    total_checks  = 0;
    passed_checks = 0;
    reset = 1'b1;
    bus_if.sensor_exit  = 1'b0;
    bus_if.sensor_gone  = 1'b0;
    bus_if.ticket       = 4'b0000;
    bus_if.ticket_valid = 1'b0;
    bus_if.countcar     = 4'd3;

    // Reset held for three edges
    tick();
    exp_out("reset_a", S_IDLE, 2'd0, 1'b0); tick();
    exp_out("reset_b", S_IDLE, 2'd0, 1'b0); tick();
    reset = 1'b0;
    exp_out("idle_quiet", S_IDLE, 2'd0, 1'b0); tick();

    // Normal exit with correct ticket
    bus_if.sensor_exit = 1'b1;
    exp_out("enter_wait", S_WAIT, 2'd0, 1'b0); tick();
    bus_if.ticket = 4'b1011; bus_if.ticket_valid = 1'b1;
    exp_out("good_ticket_open", S_OPEN, 2'd0, 1'b0); tick();
    total_checks++;
    if (bus_if.GREEN_LED === 1'b1 && bus_if.RED_LED === 1'b0) passed_checks++;
    else $display("FAIL direct_open_leds: g=%b r=%b", bus_if.GREEN_LED, bus_if.RED_LED);
    bus_if.ticket_valid = 1'b0; bus_if.sensor_exit = 1'b0;
    exp_out("open_hold", S_OPEN, 2'd0, 1'b0); tick();
    bus_if.sensor_gone = 1'b1;
    exp_out("car_left_pulse", S_IDLE, 2'd0, 1'b1); tick();
    total_checks++;
    if (bus_if.car_left === 1'b1 && bus_if.indicator === S_IDLE) passed_checks++;
    else $display("FAIL direct_car_left: cl=%b ind=%b", bus_if.car_left, bus_if.indicator);
    bus_if.sensor_gone = 1'b0;
    exp_out("car_left_drop", S_IDLE, 2'd0, 1'b0); tick();

    // Three wrong tickets -> lockout, only reset recovers
    bus_if.sensor_exit = 1'b1;
    exp_out("wait_for_wrong", S_WAIT, 2'd0, 1'b0); tick();
    bus_if.sensor_exit = 1'b0;
    bus_if.ticket = 4'b1001; bus_if.ticket_valid = 1'b1;
    exp_out("wrong_1", S_WRONG, 2'd1, 1'b0); tick();
    bus_if.ticket_valid = 1'b0;
    exp_out("wrong_1_hold", S_WRONG, 2'd1, 1'b0); tick();
    bus_if.ticket_valid = 1'b1;
    exp_out("wrong_2", S_WRONG, 2'd2, 1'b0); tick();
    bus_if.ticket_valid = 1'b0;
    exp_out("wrong_2_hold", S_WRONG, 2'd2, 1'b0); tick();
    bus_if.ticket_valid = 1'b1;
    exp_out("lockout", S_LOCK, 2'd3, 1'b0); tick();
    total_checks++;
    if (bus_if.alarm === 1'b1 && bus_if.indicator === S_LOCK) passed_checks++;
    else $display("FAIL direct_lockout: al=%b ind=%b", bus_if.alarm, bus_if.indicator);
    bus_if.ticket_valid = 1'b0;
    exp_out("lockout_hold", S_LOCK, 2'd3, 1'b0); tick();
    bus_if.ticket = 4'b1011; bus_if.ticket_valid = 1'b1;
    exp_out("lockout_ignores_good", S_LOCK, 2'd3, 1'b0); tick();
    bus_if.ticket_valid = 1'b0; bus_if.sensor_gone = 1'b1;
    exp_out("lockout_ignores_gone", S_LOCK, 2'd3, 1'b0); tick();
    bus_if.sensor_gone = 1'b0; reset = 1'b1;
    exp_out("lockout_reset", S_IDLE, 2'd0, 1'b0); tick();
    reset = 1'b0;
    exp_out("post_lockout_idle", S_IDLE, 2'd0, 1'b0); tick();

    // Empty lot fault
    bus_if.countcar = 4'd0; bus_if.sensor_exit = 1'b1;
    exp_out("fault", S_FAULT, 2'd0, 1'b0); tick();
    total_checks++;
    if (bus_if.indicator === S_FAULT && bus_if.alarm === 1'b1) passed_checks++;
    else $display("FAIL direct_fault: ind=%b al=%b", bus_if.indicator, bus_if.alarm);
    exp_out("fault_hold", S_FAULT, 2'd0, 1'b0); tick();
    bus_if.sensor_exit = 1'b0;
    exp_out("fault_clear", S_IDLE, 2'd0, 1'b0); tick();
    bus_if.countcar = 4'd3;

    // Timeout after 30 cycles in WAIT_TICKET; sensor_gone ignored there
    bus_if.sensor_exit = 1'b1;
    exp_out("timeout_enter", S_WAIT, 2'd0, 1'b0); tick();
    bus_if.sensor_exit = 1'b0;
    for (int unsigned i = 0; i < 29; i++) begin
      bus_if.sensor_gone = (i == 5);
      exp_out("timeout_wait", S_WAIT, 2'd0, 1'b0); tick();
    end
    bus_if.sensor_gone = 1'b0;
    exp_out("timeout_idle", S_IDLE, 2'd0, 1'b0); tick();

    // Strobe on the last allowed cycle wins over timeout
    bus_if.sensor_exit = 1'b1;
    exp_out("late_enter", S_WAIT, 2'd0, 1'b0); tick();
    bus_if.sensor_exit = 1'b0;
    for (int unsigned i = 0; i < 29; i++) begin
      exp_out("late_wait", S_WAIT, 2'd0, 1'b0); tick();
    end
    bus_if.ticket = 4'b1011; bus_if.ticket_valid = 1'b1;
    exp_out("late_ticket_open", S_OPEN, 2'd0, 1'b0); tick();
    bus_if.ticket_valid = 1'b0; bus_if.sensor_gone = 1'b1;
    exp_out("late_car_left", S_IDLE, 2'd0, 1'b1); tick();
    bus_if.sensor_gone = 1'b0;

    // No timeout in WRONG, then correct ticket, then tailgate
    bus_if.sensor_exit = 1'b1;
    exp_out("tg_enter", S_WAIT, 2'd0, 1'b0); tick();
    bus_if.sensor_exit = 1'b0;
    bus_if.ticket = 4'b0000; bus_if.ticket_valid = 1'b1;
    exp_out("tg_wrong", S_WRONG, 2'd1, 1'b0); tick();
    bus_if.ticket_valid = 1'b0;
    for (int unsigned i = 0; i < 40; i++) begin
      exp_out("wrong_no_timeout", S_WRONG, 2'd1, 1'b0); tick();
    end
    bus_if.ticket = 4'b1011; bus_if.ticket_valid = 1'b1;
    exp_out("wrong_to_open", S_OPEN, 2'd1, 1'b0); tick();
    bus_if.ticket_valid = 1'b0;
    bus_if.sensor_gone = 1'b1; bus_if.sensor_exit = 1'b1;
    exp_out("tailgate", S_WAIT, 2'd0, 1'b1); tick();
    total_checks++;
    if (bus_if.indicator === S_WAIT && bus_if.car_left === 1'b1) passed_checks++;
    else $display("FAIL direct_tailgate: ind=%b cl=%b", bus_if.indicator, bus_if.car_left);
    bus_if.sensor_gone = 1'b0; bus_if.sensor_exit = 1'b0;
    for (int unsigned i = 0; i < 29; i++) begin
      exp_out("tailgate_timer_restart", S_WAIT, 2'd0, 1'b0); tick();
    end
    exp_out("tailgate_timeout", S_IDLE, 2'd0, 1'b0); tick();

    // Reset while OPEN overrides a simultaneous departure
    bus_if.sensor_exit = 1'b1;
    exp_out("rst_open_enter", S_WAIT, 2'd0, 1'b0); tick();
    bus_if.sensor_exit = 1'b0; bus_if.ticket_valid = 1'b1;
    exp_out("rst_open_open", S_OPEN, 2'd0, 1'b0); tick();
    bus_if.ticket_valid = 1'b0; bus_if.sensor_gone = 1'b1; reset = 1'b1;
    exp_out("reset_in_open", S_IDLE, 2'd0, 1'b0); tick();
    total_checks++;
    if (bus_if.GREEN_LED === 1'b0 && bus_if.car_left === 1'b0 && bus_if.indicator === S_IDLE)
      passed_checks++;
    else $display("FAIL direct_reset_open: g=%b cl=%b ind=%b",
                  bus_if.GREEN_LED, bus_if.car_left, bus_if.indicator);
    bus_if.sensor_gone = 1'b0; reset = 1'b0;
    exp_out("after_reset_open", S_IDLE, 2'd0, 1'b0); tick();

    tick();
    tick();
    while (sb.size() > 0) begin
      total_checks++;
      $display("FAIL %s: expectation for cyc=%0d never compared, now cyc=%0d",
               sb[0].name, sb[0].cyc, cyc);
      void'(sb.pop_front());
    end
    if (passed_checks == total_checks) $display("PASS");
    else $display("FAIL %0d checks failed", total_checks - passed_checks);
    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule

// File: doc/parking_exit_gate.md
PARKING_EXIT_GATE -- requirements
Module: parking_exit_gate

Interface
REQ-001 SHALL have parameters: EXIT_CODE, 4'b1011, valid exit ticket code; WAIT_LIMIT, 8'd30, cycles allowed in WAIT_TICKET before timeout; MAX_ATTEMPTS, 2'd3, wrong tickets before lockout.
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 sensor_exit  input  1  car present at exit barrier.
REQ-005 sensor_gone  input  1  car has cleared exit barrier.
REQ-006 ticket  input  4  exit code presented by driver.
REQ-007 ticket_valid  input  1  one-cycle strobe; ticket sampled only when high.
REQ-008 countcar  input  4  current occupancy from the entry-side controller.
REQ-009 GREEN_LED  output  1  barrier open.
REQ-010 RED_LED  output  1  barrier closed, action required or fault.
REQ-011 indicator  output  3  current state code.
REQ-012 car_left  output  1  one-cycle pulse per departed car (decrement request to entry side).
REQ-013 attempts  output  2  consecutive wrong tickets for current car.
REQ-014 alarm  output  1  lockout or empty-lot fault.

Function
REQ-015 SHALL be a Moore FSM; all outputs registered/decoded from state register only, visible the cycle after the deciding edge.
REQ-016 State codes on indicator: IDLE 000, WAIT_TICKET 001, WRONG 010, OPEN 011, FAULT 100, LOCKOUT 101.
REQ-017 LEDs: IDLE both 0; WAIT_TICKET, WRONG, FAULT, LOCKOUT RED=1 GREEN=0; OPEN GREEN=1 RED=0; never both 1.
REQ-018 alarm SHALL be 1 only in FAULT and LOCKOUT.
REQ-019 IDLE: sensor_exit=1 and countcar!=0 -> WAIT_TICKET with timer cleared; sensor_exit=1 and countcar==0 -> FAULT.
REQ-020 FAULT: stays until sensor_exit=0, then IDLE.
REQ-021 WAIT_TICKET: 8-bit timer increments each cycle; ticket_valid with ticket==EXIT_CODE -> OPEN; ticket_valid with mismatch -> WRONG, attempts+1.
REQ-022 WAIT_TICKET: timer reaching WAIT_LIMIT-1 with no ticket_valid -> IDLE, attempts cleared; ticket_valid on that same cycle takes priority over timeout.
REQ-023 WRONG: correct ticket -> OPEN; wrong ticket -> attempts+1, stay WRONG; no timeout in WRONG.
REQ-024 attempts reaching MAX_ATTEMPTS SHALL move to LOCKOUT on that same edge; LOCKOUT exits only by reset.
REQ-025 attempts saturate at MAX_ATTEMPTS, never wrap.
REQ-026 OPEN: ticket_valid ignored; sensor_gone=1 -> car_left=1 for exactly one cycle, attempts cleared, next state IDLE.
REQ-027 OPEN with sensor_gone=1 and sensor_exit=1 same cycle (tailgate) -> car_left pulse, next state WAIT_TICKET, timer cleared.
REQ-028 car_left SHALL never assert outside the cycle following an OPEN exit; never two consecutive cycles.
REQ-029 sensor_gone outside OPEN SHALL be ignored.

Reset
REQ-030 reset=1 at a clock edge SHALL force IDLE, timer=0, attempts=0, car_left=0, alarm=0, GREEN=0, RED=0, indicator=000, overriding all inputs and any state including LOCKOUT and mid-OPEN.
REQ-031 Behaviour before first reset edge is undefined; bench SHALL apply reset ≥2 cycles.

Verification
REQ-032 countcar=3, sensor_exit=1, ticket=1011 strobed -> indicator 001 then 011, GREEN=1; sensor_gone=1 -> car_left one-cycle pulse, indicator 000.
REQ-033 ticket=1001 strobed three times in WAIT_TICKET/WRONG -> attempts 1,2 with indicator 010, third -> indicator 101, alarm=1, RED=1; ticket 1011 afterwards ignored; reset -> indicator 000, attempts 0.
REQ-034 countcar=0, sensor_exit=1 -> indicator 100, alarm=1; sensor_exit=0 -> indicator 000, alarm=0.
REQ-035 WAIT_TICKET with no strobe for 30 cycles -> indicator 000 exactly at timeout; strobe on cycle 30 -> OPEN instead.
REQ-036 OPEN with sensor_gone=1 and sensor_exit=1 together -> car_left pulse, indicator 001, timer restarted.
REQ-037 reset asserted while OPEN -> next cycle GREEN=0, car_left=0, indicator 000.
